// File: rtl/glm_dma_write_engine.sv
// Purpose: GLM writeback DMA engine; buffers pushed 512-bit lines, issues one host write per line at consecutive addresses.
// Latency: a line pushed at cycle t appears on o_host_req_* at t+2 at the earliest; order is strictly FIFO.
// Backpressure: o_wr_almostfull asserts with AF_SLACK entries free or outside ACTIVE; i_host_almostfull stalls pops.
// Ports: clk/reset (sync, active-high); i_ctl_* job start (base line address, line count); o_status_* engine state;
//        i_wr_we/i_wr_wdata line push, o_wr_almostfull push throttle, o_wr_ack per-line ack echo;
//        o_host_req_* write request, i_host_almostfull host throttle, i_host_ack line ack; o_err sticky protocol error.
module glm_dma_write_engine #(
  parameter int ADDR_WIDTH = 42,
  parameter int DATA_WIDTH = 512,
  parameter int FIFO_DEPTH = 64,
  parameter int AF_SLACK   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_ctl_start,
  input  logic [ADDR_WIDTH-1:0] i_ctl_addr,
  input  logic [31:0]           i_ctl_length,
  output logic                  o_status_idle,
  output logic                  o_status_active,
  input  logic                  i_wr_we,
  input  logic [DATA_WIDTH-1:0] i_wr_wdata,
  output logic                  o_wr_almostfull,
  output logic                  o_wr_ack,
  output logic                  o_host_req_valid,
  output logic [ADDR_WIDTH-1:0] o_host_req_addr,
  output logic [DATA_WIDTH-1:0] o_host_req_data,
  input  logic                  i_host_almostfull,
  input  logic                  i_host_ack,
  output logic                  o_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] AF_LEVEL   = CW'(FIFO_DEPTH - AF_SLACK);
  localparam logic [CW-1:0] FULL_LEVEL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [31:0]           r_len;
  logic [31:0]           r_sent;
  logic [31:0]           r_accepted;
  logic [31:0]           r_acked;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [CW-1:0]         r_wptr;
  logic [CW-1:0]         r_rptr;
  logic                  r_idle;
  logic                  r_active;
  logic                  r_af;
  logic                  r_wr_ack;
  logic                  r_req_valid;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic [DATA_WIDTH-1:0] r_req_data;
  logic                  r_err;

  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ack_ok;
  logic                  w_start_ok;
  logic                  w_err_set;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count     = r_wptr - r_rptr;
  assign w_push      = i_wr_we && (r_state == S_ACTIVE) && (r_accepted < r_len) && (w_count != FULL_LEVEL);
  assign w_pop       = (w_count != '0) && !i_host_almostfull;
  // An ack is only legitimate for a line that has already been issued.
  assign w_ack_ok    = i_host_ack && (r_acked < r_sent);
  assign w_start_ok  = i_ctl_start && (r_state == S_IDLE);
  assign w_err_set   = (i_ctl_start && !w_start_ok) || (i_wr_we && !w_push) || (i_host_ack && !w_ack_ok);
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok && (i_ctl_length != 32'd0)) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if ((r_accepted == r_len) && (r_sent == r_len)) w_state_nxt = S_DRAIN;
      S_DRAIN:  if (r_acked == r_len) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Line storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= i_wr_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_idle      <= 1'b1;
      r_active    <= 1'b0;
      r_af        <= 1'b1;
      r_wr_ack    <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_addr  <= '0;
      r_req_data  <= '0;
      r_err       <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_base      <= '0;
      r_len       <= 32'd0;
      r_sent      <= 32'd0;
      r_accepted  <= 32'd0;
      r_acked     <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_idle      <= (w_state_nxt == S_IDLE);
      r_active    <= (w_state_nxt == S_ACTIVE);
      // Computed from next-cycle occupancy so the flag is exact in the cycle it is seen.
      r_af        <= (w_count_nxt >= AF_LEVEL) || (w_state_nxt != S_ACTIVE);
      r_wr_ack    <= w_ack_ok;
      r_req_valid <= w_pop;
      if (w_err_set) r_err <= 1'b1;
      if (w_push) begin
        r_wptr     <= r_wptr + CW'(1);
        r_accepted <= r_accepted + 32'd1;
      end
      if (w_pop) begin
        r_rptr     <= r_rptr + CW'(1);
        r_sent     <= r_sent + 32'd1;
        // Address wraps naturally at 2^ADDR_WIDTH.
        r_req_addr <= r_base + ADDR_WIDTH'(r_sent);
        r_req_data <= r_mem[r_rptr[PW-1:0]];
      end
      if (w_ack_ok) r_acked <= r_acked + 32'd1;
      // A start is only taken in IDLE, where no pops or valid acks occur, so clearing here is safe.
      if (w_start_ok) begin
        r_base     <= i_ctl_addr;
        r_len      <= i_ctl_length;
        r_sent     <= 32'd0;
        r_accepted <= 32'd0;
        r_acked    <= 32'd0;
      end
    end
  end

  assign o_status_idle    = r_idle;
  assign o_status_active  = r_active;
  assign o_wr_almostfull  = r_af;
  assign o_wr_ack         = r_wr_ack;
  assign o_host_req_valid = r_req_valid;
  assign o_host_req_addr  = r_req_addr;
  assign o_host_req_data  = r_req_data;
  assign o_err            = r_err;

endmodule

// File: tb/tb_glm_dma_write_engine.sv
module tb_glm_dma_write_engine;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int DEPTH = 64;
  localparam int SLACK = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          ctl_start;
  logic [AW-1:0] ctl_addr;
  logic [31:0]   ctl_length;
  logic          status_idle, status_active;
  logic          wr_we;
  logic [DW-1:0] wr_wdata;
  logic          wr_af, wr_ack;
  logic          req_vld;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic          host_af, host_ack;
  logic          err;

  always #5 clk = ~clk;

  glm_dma_write_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_SLACK(SLACK)) dut (
    .clk(clk), .reset(reset),
    .i_ctl_start(ctl_start), .i_ctl_addr(ctl_addr), .i_ctl_length(ctl_length),
    .o_status_idle(status_idle), .o_status_active(status_active),
    .i_wr_we(wr_we), .i_wr_wdata(wr_wdata), .o_wr_almostfull(wr_af), .o_wr_ack(wr_ack),
    .o_host_req_valid(req_vld), .o_host_req_addr(req_addr), .o_host_req_data(req_data),
    .i_host_almostfull(host_af), .i_host_ack(host_ack), .o_err(err)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- behavioural reference model + compare process ----------------
  int              m_phase;   // 0 idle, 1 accepting lines, 2 waiting for acks
  logic [AW-1:0]   m_base;
  longint unsigned m_len, m_sent, m_acc, m_acked;
  logic [DW-1:0]   m_q[$];
  logic            m_idle, m_active, m_af, m_wrack, m_vld, m_err;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;
  bit              m_ok = 1'b0;
  logic [AW-1:0]   log_addr[$];
  logic [DW-1:0]   log_data[$];
  int              wrack_cnt = 0;
  int              active_cyc = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset === 1'b1) begin
        m_phase = 0; m_base = '0; m_len = 0; m_sent = 0; m_acc = 0; m_acked = 0;
        m_q.delete();
        m_idle = 1'b1; m_active = 1'b0; m_af = 1'b1; m_wrack = 1'b0; m_vld = 1'b0; m_err = 1'b0;
        m_ok = 1'b1;
      end else if (m_ok) begin
        bit pop, push, ackok;
        int nphase;
        pop   = (m_q.size() != 0) && !host_af;
        push  = wr_we && (m_phase == 1) && (m_acc < m_len) && (m_q.size() < DEPTH);
        ackok = host_ack && (m_acked < m_sent);
        if ((ctl_start && m_phase != 0) || (wr_we && !push) || (host_ack && !ackok)) m_err = 1'b1;
        nphase = m_phase;
        if (m_phase == 1 && m_acc == m_len && m_sent == m_len) nphase = 2;
        if (m_phase == 2 && m_acked == m_len) nphase = 0;
        m_wrack = ackok;
        m_vld   = pop;
        if (pop) begin
          m_addr = m_base + AW'(m_sent);
          m_data = m_q.pop_front();
          m_sent++;
        end
        if (push) begin
          m_q.push_back(wr_wdata);
          m_acc++;
        end
        if (ackok) m_acked++;
        if (m_phase == 0 && ctl_start) begin
          m_base = ctl_addr; m_len = ctl_length; m_sent = 0; m_acc = 0; m_acked = 0;
          if (ctl_length != 0) nphase = 1;
        end
        m_phase  = nphase;
        m_idle   = (nphase == 0);
        m_active = (nphase == 1);
        m_af     = (m_q.size() >= DEPTH - SLACK) || (nphase != 1);
      end
      @(negedge clk);
      if (m_ok) begin
        chk("status_idle",   DW'(status_idle),   DW'(m_idle));
        chk("status_active", DW'(status_active), DW'(m_active));
        chk("wr_almostfull", DW'(wr_af),         DW'(m_af));
        chk("wr_ack",        DW'(wr_ack),        DW'(m_wrack));
        chk("host_req_valid", DW'(req_vld),      DW'(m_vld));
        chk("err",           DW'(err),           DW'(m_err));
        if (m_vld) begin
          chk("host_req_addr", DW'(req_addr), DW'(m_addr));
          chk("host_req_data", req_data, m_data);
        end
        if (req_vld === 1'b1) begin
          log_addr.push_back(req_addr);
          log_data.push_back(req_data);
        end
        if (wr_ack === 1'b1) wrack_cnt++;
        if (status_active === 1'b1) active_cyc++;
      end
    end
  end

  // ---------------- producer ----------------
  int            prod_target = 0, prod_done = 0;
  int            extra_req = 0, extra_done = 0;
  int            pflush_req = 0, pflush_done = 0;
  bit            prod_burst = 1'b1;
  logic [DW-1:0] push_log[$];

  initial begin
    wr_we = 1'b0;
    wr_wdata = '0;
    forever begin
      @(posedge clk); #1;
      wr_we = 1'b0;
      if (pflush_req != pflush_done) begin
        prod_done = prod_target;
        pflush_done++;
      end else if (extra_req != extra_done) begin
        wr_we = 1'b1; wr_wdata = rnd512(); extra_done++;
      end else if (prod_done < prod_target && wr_af === 1'b0 && (prod_burst || $urandom_range(0, 2) != 0)) begin
        wr_we = 1'b1; wr_wdata = rnd512(); prod_done++;
        push_log.push_back(wr_wdata);
      end
    end
  end

  // ---------------- host responder ----------------
  int resp_min = 5, resp_max = 5, resp_gap = 1;
  int rflush_req = 0, rflush_done = 0, stray_req = 0, stray_done = 0;
  int due_q[$];
  int last_due = 0;

  initial begin
    host_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (req_vld === 1'b1) begin
        int d;
        d = cyc + $urandom_range(resp_min, resp_max);
        if (d < last_due + resp_gap) d = last_due + resp_gap;
        last_due = d;
        due_q.push_back(d);
      end
      @(posedge clk); #1;
      host_ack = 1'b0;
      if (rflush_req != rflush_done) begin
        due_q.delete();
        rflush_done++;
      end
      if (stray_req != stray_done) begin
        host_ack = 1'b1; stray_done++;
      end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
        host_ack = 1'b1;
        void'(due_q.pop_front());
      end
    end
  end

  // ---------------- sequence helpers ----------------
  bit rand_haf = 1'b0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; rflush_req++; pflush_req++;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic start_job(input logic [AW-1:0] a, input int unsigned len);
    ctl_start = 1'b1; ctl_addr = a; ctl_length = len;
    step();
    ctl_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && status_idle !== 1'b1; i++) begin
      if (rand_haf) host_af = 1'($urandom_range(0, 1));
      step();
    end
    host_af = 1'b0;
    if (status_idle !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout, status_idle=%b required 1", name, status_idle);
    end
  endtask

  task automatic wait_reqs(input string name, input int target, input int budget);
    for (int i = 0; i < budget && log_addr.size() < target; i++) step();
    if (log_addr.size() < target) begin
      vectors++; miscompares++;
      $display("FAIL %s: timeout, %0d requests seen, required %0d", name, log_addr.size(), target);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 50000", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b, pb, pl, a0, ac;
    logic [AW-1:0] exp_wrap [4];
    logic [63:0] t64;

    reset = 1'b1; ctl_start = 1'b0; ctl_addr = '0; ctl_length = 32'd0; host_af = 1'b0;
    step(); step(); step();
    chk("reset_idle", DW'(status_idle), DW'(1'b1));
    chk("reset_af", DW'(wr_af), DW'(1'b1));
    chk("reset_err", DW'(err), DW'(1'b0));
    chk("reset_vld", DW'(req_vld), DW'(1'b0));
    reset = 1'b0;
    step();

    // Basic job
    resp_min = 5; resp_max = 5; resp_gap = 1; prod_burst = 1'b1;
    b = log_addr.size(); pl = push_log.size(); a0 = wrack_cnt;
    start_job(42'h1000, 4);
    prod_target += 4;
    wait_idle("basic_done", 200);
    chk("basic_nreq", DW'(log_addr.size() - b), DW'(4));
    for (int i = 0; i < 4; i++) begin
      chk("basic_addr", DW'(log_addr[b+i]), DW'(AW'(64'h1000 + 64'(i))));
      chk("basic_data", log_data[b+i], push_log[pl+i]);
    end
    chk("basic_wrack", DW'(wrack_cnt - a0), DW'(4));
    chk("basic_err", DW'(err), DW'(1'b0));

    // Back-pressure
    do_reset();
    host_af = 1'b1;
    b = log_addr.size(); pb = prod_done;
    start_job(42'h2000, 100);
    prod_target += 100;
    for (int i = 0; i < 80; i++) step();
    chk("bp_accepted", DW'(prod_done - pb), DW'(56));
    chk("bp_af", DW'(wr_af), DW'(1'b1));
    chk("bp_noreq", DW'(log_addr.size() - b), DW'(0));
    host_af = 1'b0;
    wait_idle("bp_done", 800);
    chk("bp_nreq", DW'(log_addr.size() - b), DW'(100));
    for (int i = 0; i < 100; i++) chk("bp_addr", DW'(log_addr[b+i]), DW'(AW'(64'h2000 + 64'(i))));
    chk("bp_err", DW'(err), DW'(1'b0));

    // Fence / overlapping start
    do_reset();
    resp_min = 20; resp_max = 20; resp_gap = 10;
    a0 = wrack_cnt; b = log_addr.size();
    start_job(42'h3000, 3);
    prod_target += 3;
    for (int i = 0; i < 200 && wrack_cnt - a0 < 1; i++) step();
    chk("fence_one_ack", DW'(wrack_cnt - a0), DW'(1));
    chk("fence_err_before", DW'(err), DW'(1'b0));
    start_job(42'h3800, 5);
    chk("fence_err", DW'(err), DW'(1'b1));
    chk("fence_busy", DW'(status_idle), DW'(1'b0));
    wait_idle("fence_drain", 200);
    chk("fence_wrack", DW'(wrack_cnt - a0), DW'(3));
    start_job(42'h4000, 1);
    prod_target += 1;
    chk("fence_restart", DW'(status_active), DW'(1'b1));
    wait_idle("fence_restart_done", 200);
    chk("fence_nreq", DW'(log_addr.size() - b), DW'(4));
    chk("fence_addr", DW'(log_addr[b+3]), DW'(AW'(64'h4000)));

    // Address wrap
    do_reset();
    resp_min = 3; resp_max = 8; resp_gap = 1;
    exp_wrap[0] = 42'h3FF_FFFF_FFFE; exp_wrap[1] = 42'h3FF_FFFF_FFFF;
    exp_wrap[2] = 42'h000_0000_0000; exp_wrap[3] = 42'h000_0000_0001;
    b = log_addr.size();
    start_job(42'h3FF_FFFF_FFFE, 4);
    prod_target += 4;
    wait_idle("wrap_done", 200);
    for (int i = 0; i < 4; i++) chk("wrap_addr", DW'(log_addr[b+i]), DW'(exp_wrap[i]));

    // Length 0, excess push, stray ack
    do_reset();
    b = log_addr.size(); ac = active_cyc;
    start_job(42'h5000, 0);
    for (int i = 0; i < 10; i++) step();
    chk("len0_nreq", DW'(log_addr.size() - b), DW'(0));
    chk("len0_active", DW'(active_cyc - ac), DW'(0));
    chk("len0_err", DW'(err), DW'(1'b0));
    start_job(42'h5100, 2);
    prod_target += 2;
    wait_idle("excess_job", 200);
    chk("excess_pre_err", DW'(err), DW'(1'b0));
    extra_req++;
    step(); step(); step();
    chk("excess_err", DW'(err), DW'(1'b1));
    chk("excess_nreq", DW'(log_addr.size() - b), DW'(2));
    do_reset();
    a0 = wrack_cnt;
    stray_req++;
    step(); step(); step();
    chk("stray_err", DW'(err), DW'(1'b1));
    chk("stray_wrack", DW'(wrack_cnt - a0), DW'(0));

    // Reset in the middle of a job
    do_reset();
    resp_min = 10; resp_max = 10; resp_gap = 1;
    b = log_addr.size();
    start_job(42'h6000, 8);
    prod_target += 8;
    wait_reqs("midrst_three", b + 3, 100);
    reset = 1'b1; rflush_req++; pflush_req++;
    step();
    chk("midrst_idle", DW'(status_idle), DW'(1'b1));
    chk("midrst_af", DW'(wr_af), DW'(1'b1));
    chk("midrst_vld", DW'(req_vld), DW'(1'b0));
    step();
    reset = 1'b0;
    step();
    b = log_addr.size(); pl = push_log.size();
    start_job(42'h7000, 2);
    prod_target += 2;
    wait_idle("midrst_fresh", 200);
    chk("midrst_nreq", DW'(log_addr.size() - b), DW'(2));
    for (int i = 0; i < 2; i++) begin
      chk("midrst_addr", DW'(log_addr[b+i]), DW'(AW'(64'h7000 + 64'(i))));
      chk("midrst_data", log_data[b+i], push_log[pl+i]);
    end

    // Randomized jobs
    do_reset();
    resp_min = 1; resp_max = 12; resp_gap = 1;
    rand_haf = 1'b1;
    for (int j = 0; j < 20; j++) begin
      int unsigned len;
      len = $urandom_range(1, 30);
      t64 = {$urandom(), $urandom()};
      prod_burst = 1'($urandom_range(0, 1));
      b = log_addr.size();
      start_job(t64[AW-1:0], len);
      prod_target += int'(len);
      wait_idle("rand_job", 2000);
      chk("rand_nreq", DW'(log_addr.size() - b), DW'(len));
    end
    rand_haf = 1'b0;
    chk("rand_err", DW'(err), DW'(1'b0));

    step(); step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
